// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues in-order word reads to imem and buffers {pc, instr} for decode.
// Optional build macro FETCH_BYPASS_EN forwards a response to decode in the same cycle when idle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        instr_valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DropW = 16;
  localparam logic [CntW:0] DepthLimit = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]   Nop        = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]  out_q, out_d;
  logic [DropW-1:0] drop_q, drop_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;

  logic [31:0] buf_pc_q  [FIFO_DEPTH];
  logic [31:0] buf_ins_q [FIFO_DEPTH];
  logic [31:0] sh_pc_q   [FIFO_DEPTH];

  logic          accept, resp_take, resp_drop, fifo_empty, bypass, push, pop;
  logic [CntW:0] credit_used;
  logic [31:0]   resp_pc;

  // Credit counts only registered state: a pop this cycle frees no slot until next cycle.
  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DepthLimit);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign resp_drop  = imem_resp_valid && (drop_q != '0);
  assign resp_take  = imem_resp_valid && (drop_q == '0);
  assign resp_pc    = sh_pc_q[sh_rd_q];
  assign fifo_empty = (cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_take && fifo_empty && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !fifo_empty && !stall_d;
  // A bypassed word consumed by decode this cycle never enters the buffer.
  assign push = resp_take && !(bypass && !stall_d);

  always_comb begin
    instr_valid_d = 1'b1;
    instr_d       = buf_ins_q[rd_ptr_q];
    pc_d          = buf_pc_q[rd_ptr_q];
    if (fifo_empty) begin
      if (bypass) begin
        instr_d = imem_resp_data;
        pc_d    = resp_pc;
      end else begin
        instr_valid_d = 1'b0;
        instr_d       = Nop;
        pc_d          = '0;
      end
    end
  end

  assign pc_plus4_d = pc_d + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    sh_rd_d    = sh_rd_q;
    sh_wr_d    = sh_wr_q;
    if (redirect_valid) begin
      // Every request still in flight returns a stale word that must be discarded.
      fetch_pc_d = redirect_pc & ~32'h3;
      drop_d     = drop_q + DropW'(out_q) - DropW'(imem_resp_valid);
      out_d      = '0;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      sh_rd_d    = '0;
      sh_wr_d    = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        sh_wr_d    = sh_wr_q + PtrW'(1);
      end
      if (resp_take) begin
        sh_rd_d = sh_rd_q + PtrW'(1);
      end
      if (resp_drop) begin
        drop_d = drop_q - DropW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      out_d = out_q + CntW'(accept) - CntW'(resp_take);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      sh_rd_q    <= '0;
      sh_wr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      sh_rd_q    <= sh_rd_d;
      sh_wr_q    <= sh_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sh_pc_q[sh_wr_q] <= fetch_pc_q;
    end
    if (push && !redirect_valid && !rst) begin
      buf_pc_q[wr_ptr_q]  <= resp_pc;
      buf_ins_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule
